// File: rtl/ccastles_vram_arbiter.sv
// Bitmap video RAM arbiter for ccastles: video > CPU > clear engine, one RAM slot per cycle.
module ccastles_vram_arbiter #(
    parameter int unsigned          ADDR_W         = 15,
    parameter int unsigned          DATA_W         = 8,
    parameter bit                   CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0]    CLEAR_VAL      = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic              vid_overrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              clr_start,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                clear_busy_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_din_q;
    logic                ram_we_q;
    logic                vid_pend_q;
    logic [ADDR_W-1:0]   vid_pend_addr_q;
    logic                vid_overrun_q;
    logic                vid_s1_q;
    logic                vid_s2_q;
    logic                vid_valid_q;
    logic [DATA_W-1:0]   vid_data_q;
    logic                cpu_out_q;
    logic                cpu_wr_s1_q;
    logic                cpu_rd_s1_q;
    logic                cpu_rd_s2_q;
    logic                cpu_ack_q;
    logic [DATA_W-1:0]   cpu_rdata_q;

    logic                vid_gnt;
    logic                cpu_gnt;
    logic                clr_gnt;
    logic [ADDR_W-1:0]   vid_gnt_addr;

    // Slot arbitration: exactly one of video, CPU or clear may own the next RAM cycle.
    always_comb begin
        vid_gnt      = vid_req | vid_pend_q;
        vid_gnt_addr = vid_pend_q ? vid_pend_addr_q : vid_addr;
        cpu_gnt      = !vid_gnt && cpu_req && !clear_busy_q && !cpu_out_q;
        clr_gnt      = !vid_gnt && !cpu_gnt && (state_q == S_CLEAR);
    end

    // RAM port, read-return pipelines, clear sequencer and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= RST_STATE;
            clr_cnt_q       <= '0;
            clear_busy_q    <= CLEAR_ON_RESET;
            ram_addr_q      <= '0;
            ram_din_q       <= '0;
            ram_we_q        <= 1'b0;
            vid_pend_q      <= 1'b0;
            vid_pend_addr_q <= '0;
            vid_overrun_q   <= 1'b0;
            vid_s1_q        <= 1'b0;
            vid_s2_q        <= 1'b0;
            vid_valid_q     <= 1'b0;
            vid_data_q      <= '0;
            cpu_out_q       <= 1'b0;
            cpu_wr_s1_q     <= 1'b0;
            cpu_rd_s1_q     <= 1'b0;
            cpu_rd_s2_q     <= 1'b0;
            cpu_ack_q       <= 1'b0;
            cpu_rdata_q     <= '0;
        end else begin
            ram_we_q <= 1'b0;

            if (vid_gnt) begin
                ram_addr_q <= vid_gnt_addr;
            end else if (cpu_gnt) begin
                ram_addr_q <= cpu_addr;
                ram_din_q  <= cpu_wdata;
                ram_we_q   <= cpu_we;
            end else if (clr_gnt) begin
                ram_addr_q <= clr_cnt_q;
                ram_din_q  <= CLEAR_VAL;
                ram_we_q   <= 1'b1;
                clr_cnt_q  <= clr_cnt_q + ADDR_W'(1);
            end

            // A request colliding with a still-pending one is dropped and flagged.
            if (vid_req && vid_pend_q) begin
                vid_overrun_q <= 1'b1;
            end
            if (vid_req && !vid_gnt) begin
                vid_pend_q      <= 1'b1;
                vid_pend_addr_q <= vid_addr;
            end else if (vid_gnt) begin
                vid_pend_q      <= 1'b0;
            end

            vid_s1_q    <= vid_gnt;
            vid_s2_q    <= vid_s1_q;
            vid_valid_q <= vid_s2_q;
            if (vid_s2_q) begin
                vid_data_q <= ram_dout;
            end

            cpu_wr_s1_q <= cpu_gnt && cpu_we;
            cpu_rd_s1_q <= cpu_gnt && !cpu_we;
            cpu_rd_s2_q <= cpu_rd_s1_q;
            cpu_ack_q   <= cpu_wr_s1_q | cpu_rd_s2_q;
            if (cpu_rd_s2_q) begin
                cpu_rdata_q <= ram_dout;
            end

            // Outstanding from grant through the ack cycle inclusive.
            if (cpu_gnt) begin
                cpu_out_q <= 1'b1;
            end else if (cpu_ack_q) begin
                cpu_out_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (clr_start) begin
                        state_q      <= S_CLEAR;
                        clr_cnt_q    <= '0;
                        clear_busy_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_gnt && (&clr_cnt_q)) begin
                        state_q      <= S_IDLE;
                        clear_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign ram_we      = ram_we_q;
    assign vid_data    = vid_data_q;
    assign vid_valid   = vid_valid_q;
    assign vid_overrun = vid_overrun_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign clear_busy  = clear_busy_q;

endmodule

// File: tb/tb_ccastles_vram_arbiter.sv
// Scoreboard bench for ccastles_vram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_ccastles_vram_arbiter;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam logic [7:0]  CLR    = 8'h5A;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic              vid_overrun;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              clr_start;
    logic              clear_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    ccastles_vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(CLR)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_overrun(vid_overrun),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .clr_start(clr_start), .clear_busy(clear_busy),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Synchronous RAM: write-enable port plus registered read data.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct { int cyc; logic [3:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int cyc; logic rd; logic [7:0] data; } rsp_t;

    wr_t  wr_q[$];
    rsp_t vid_q[$];
    rsp_t ack_q[$];
    wr_t  w;
    rsp_t r;

    int n_vec = 0;
    int n_err = 0;
    int c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic push_wr(input int t, input logic [3:0] a, input logic [7:0] d);
        wr_t e;
        e.cyc = t; e.addr = a; e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic push_vid(input int t, input logic [7:0] d);
        rsp_t e;
        e.cyc = t; e.rd = 1'b1; e.data = d;
        vid_q.push_back(e);
    endtask

    task automatic push_ack(input int t, input logic rd, input logic [7:0] d);
        rsp_t e;
        e.cyc = t; e.rd = rd; e.data = d;
        ack_q.push_back(e);
    endtask

    // Full clear from the current cycle's first grant, no video interference.
    task automatic push_clear(input int first_wr);
        for (int k = 0; k < 16; k++) push_wr(first_wr + k, 4'(k), CLR);
    endtask

    // One CPU transaction starting next cycle; request dropped in its ack cycle.
    task automatic cpu_txn(input logic we, input logic [3:0] a, input logic [7:0] wd,
                           input logic [7:0] rd_exp);
        int t0;
        tick();
        t0 = cyc;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        if (we) begin
            push_wr(t0 + 1, a, wd);
            push_ack(t0 + 2, 1'b0, 8'h00);
            wait_until(t0 + 2);
        end else begin
            push_ack(t0 + 3, 1'b1, rd_exp);
            wait_until(t0 + 3);
        end
        cpu_req = 1'b0;
    endtask

    // Per-cycle monitor: every expected event must appear in exactly its cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_q.size() != 0 && wr_q[0].cyc == cyc) begin
                w = wr_q.pop_front();
                chk("ram_we", 32'(ram_we), 32'd1);
                chk("ram_addr", 32'(ram_addr), 32'(w.addr));
                chk("ram_din", 32'(ram_din), 32'(w.data));
            end else begin
                chk("ram_we_idle", 32'(ram_we), 32'd0);
            end
            if (vid_q.size() != 0 && vid_q[0].cyc == cyc) begin
                r = vid_q.pop_front();
                chk("vid_valid", 32'(vid_valid), 32'd1);
                chk("vid_data", 32'(vid_data), 32'(r.data));
            end else begin
                chk("vid_valid_idle", 32'(vid_valid), 32'd0);
            end
            if (ack_q.size() != 0 && ack_q[0].cyc == cyc) begin
                r = ack_q.pop_front();
                chk("cpu_ack", 32'(cpu_ack), 32'd1);
                if (r.rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(r.data));
            end else begin
                chk("cpu_ack_idle", 32'(cpu_ack), 32'd0);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; clr_start = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) tick();

        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_vid_valid", 32'(vid_valid), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_clear_busy", 32'(clear_busy), 32'd1);
        chk("rst_overrun", 32'(vid_overrun), 32'd0);

        // Clear on reset release: 16 back-to-back writes.
        reset_n = 1'b1; c = cyc;
        push_clear(c + 1);
        wait_until(c + 15);
        chk("busy_before_last", 32'(clear_busy), 32'd1);
        tick();
        chk("busy_after_last", 32'(clear_busy), 32'd0);

        // CPU write then read back.
        cpu_txn(1'b1, 4'h3, 8'hA5, 8'h00);
        cpu_txn(1'b0, 4'h3, 8'h00, 8'hA5);

        // Video and CPU read collide: video first, CPU one cycle later.
        tick(); c = cyc;
        vid_req = 1'b1; vid_addr = 4'h3;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h0;
        push_vid(c + 3, 8'hA5);
        push_ack(c + 4, 1'b1, CLR);
        tick(); vid_req = 1'b0;
        wait_until(c + 4); cpu_req = 1'b0;

        // Three back-to-back reads with cpu_req held.
        cpu_txn(1'b1, 4'h7, 8'h3C, 8'h00);
        tick(); c = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
        push_ack(c + 3, 1'b1, 8'hA5);
        push_ack(c + 7, 1'b1, 8'h3C);
        push_ack(c + 11, 1'b1, CLR);
        tick(); chk("b2b_addr0", 32'(ram_addr), 32'h3);
        wait_until(c + 3); cpu_addr = 4'h7;
        wait_until(c + 5); chk("b2b_addr1", 32'(ram_addr), 32'h7);
        wait_until(c + 7); cpu_addr = 4'h0;
        wait_until(c + 9); chk("b2b_addr2", 32'(ram_addr), 32'h0);
        wait_until(c + 11); cpu_req = 1'b0;

        // Clear restarted by reset with video requests at clear cycles 3 and 7.
        cpu_txn(1'b1, 4'h9, 8'hC3, 8'h00);
        tick(); reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1; c = cyc;
        begin
            int a = 0;
            for (int s = 0; s < 18; s++) begin
                if (s != 3 && s != 7) begin
                    push_wr(c + s + 1, 4'(a), CLR);
                    a++;
                end
            end
        end
        wait_until(c + 3); vid_req = 1'b1; vid_addr = 4'h9;
        push_vid(c + 6, 8'hC3);
        tick(); vid_req = 1'b0;
        wait_until(c + 7); vid_req = 1'b1; vid_addr = 4'h0;
        push_vid(c + 10, CLR);
        tick(); vid_req = 1'b0;
        wait_until(c + 17);
        chk("vclr_busy_before", 32'(clear_busy), 32'd1);
        tick();
        chk("vclr_busy_after", 32'(clear_busy), 32'd0);

        // Commanded clear; a CPU write held off until the clear finishes.
        tick(); c = cyc;
        clr_start = 1'b1;
        for (int k = 0; k < 16; k++) push_wr(c + 2 + k, 4'(k), CLR);
        tick(); clr_start = 1'b0;
        chk("cmd_busy_start", 32'(clear_busy), 32'd1);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h5; cpu_wdata = 8'h77;
        push_wr(c + 18, 4'h5, 8'h77);
        push_ack(c + 19, 1'b0, 8'h00);
        wait_until(c + 16);
        chk("cmd_busy_end", 32'(clear_busy), 32'd1);
        tick();
        chk("cmd_busy_done", 32'(clear_busy), 32'd0);
        wait_until(c + 19); cpu_req = 1'b0;
        cpu_txn(1'b0, 4'h5, 8'h00, 8'h77);

        // Reset mid-clear: abort, then restart from address 0.
        tick(); reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1; c = cyc;
        for (int k = 0; k < 4; k++) push_wr(c + 1 + k, 4'(k), CLR);
        wait_until(c + 5);
        reset_n = 1'b0; #1;
        chk("midclr_ram_we", 32'(ram_we), 32'd0);
        chk("midclr_ram_addr", 32'(ram_addr), 32'd0);
        chk("midclr_busy", 32'(clear_busy), 32'd1);
        tick(); reset_n = 1'b1; c = cyc;
        push_clear(c + 1);
        wait_until(c + 16);
        chk("midclr_done", 32'(clear_busy), 32'd0);

        // Reset mid CPU read: no ack must ever appear.
        tick(); c = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
        wait_until(c + 2);
        reset_n = 1'b0; cpu_req = 1'b0; #1;
        chk("midrd_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("midrd_ram_addr", 32'(ram_addr), 32'd0);
        chk("midrd_busy", 32'(clear_busy), 32'd1);
        tick(); reset_n = 1'b1; c = cyc;
        push_clear(c + 1);
        wait_until(c + 17);
        chk("midrd_clear_done", 32'(clear_busy), 32'd0);
        cpu_txn(1'b0, 4'h3, 8'h00, CLR);
        tick(); tick();

        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("vid_q_drained", 32'(vid_q.size()), 32'd0);
        chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
        chk("overrun_clear", 32'(vid_overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ccastles_vram_arbiter.md
Name: ccastles_vram_arbiter

Overview:
Shares the single-port synchronous bitmap video RAM among three requesters: video scan-out fetch, CPU read/write, and a built-in clear engine. Video has hard priority, the CPU is next, and clear uses only idle slots. The block sits inside ccastles between the 6502 bus decode, the video fetch logic and the bitmap RAM, all clocked on clk_game. It also sequences a full RAM clear after reset or on command.

Parameters:
ADDR_W, 15, RAM address width (32 KB bitmap)
DATA_W, 8, RAM data width
CLEAR_ON_RESET, 1, 1 = run clear sequence on reset release
CLEAR_VAL, 0, data written by the clear engine

Ports:
clk  in  1  clk_game; every register is clocked on the rising edge
reset_n  in  1  asynchronous, active-low reset
vid_req  in  1  one-cycle video fetch request
vid_addr  in  ADDR_W  video fetch address, valid with vid_req
vid_data  out  DATA_W  fetched video byte
vid_valid  out  1  one-cycle strobe, vid_data valid
vid_overrun  out  1  sticky: video request lost
cpu_req  in  1  level CPU request, held until ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion strobe
cpu_rdata  out  DATA_W  read data, valid with cpu_ack on a read
clr_start  in  1  pulse: start a clear sequence
clear_busy  out  1  clear in progress; CPU accesses are held off
ram_addr  out  ADDR_W  RAM address (registered)
ram_din  out  DATA_W  RAM write data (registered)
ram_we  out  1  RAM write enable (registered)
ram_dout  in  DATA_W  RAM read data, 1-cycle latency after address

Behaviour:
- Reset (async, reset_n=0): ram_addr=0, ram_din=0, ram_we=0, vid_data=0, vid_valid=0, vid_overrun=0, cpu_ack=0, cpu_rdata=0, clear counter=0, vid_pend=0. clear_busy=CLEAR_ON_RESET. FSM goes to CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- Reset mid-operation aborts all activity. Outstanding acks and valids are never issued. A clear restarts from address 0 when CLEAR_ON_RESET=1.
- Each cycle the arbiter grants exactly one RAM slot. Its output registers load at the clock edge ending the grant cycle, so the RAM sees the access in the next cycle.
- Priority: (1) video, if vid_req or vid_pend is set; (2) CPU, if cpu_req is set, clear_busy=0 and no CPU transaction is outstanding; (3) clear, if FSM=CLEAR; (4) none, which drives ram_we=0 and holds ram_addr.
- Video timing: grant in cycle 0, ram_addr=vid_addr with ram_we=0 in cycle 1, ram_dout sampled in cycle 2, vid_valid=1 with vid_data in cycle 3.
- Video is always granted on the cycle of the request, so vid_pend is defensive only. A vid_req arriving while vid_pend is already set is dropped and sets vid_overrun, which stays set until reset.
- CPU write: grant in cycle 0; in cycle 1 ram_we=1, ram_addr=cpu_addr, ram_din=cpu_wdata; cpu_ack=1 in cycle 2.
- CPU read: grant in cycle 0, address driven in cycle 1, cpu_ack=1 with cpu_rdata in cycle 3.
- CPU is outstanding from its grant cycle through its ack cycle inclusive; cpu_req is ignored during that window.
- cpu_req still high in the cycle after ack starts a new transaction, which allows back-to-back accesses. The requester must hold cpu_addr, cpu_we and cpu_wdata stable from req assertion until ack.
- FSM has two states, IDLE and CLEAR.
  - IDLE→CLEAR on clr_start=1: clear counter=0, clear_busy=1.
  - clr_start is ignored in CLEAR.
  - In CLEAR, each clear grant writes CLEAR_VAL to the counter address and increments the counter.
  - The grant that writes address 2^ADDR_W−1 moves the FSM to IDLE. clear_busy=0 from the following cycle; the counter wraps to 0.
- A CPU transaction outstanding when clr_start arrives completes normally; new CPU grants are blocked until clear_busy=0.
- Video is served throughout a clear. Clear takes 2^ADDR_W plus the number of video grants, in cycles.
- ram_we is high only in the write slot cycle; never two RAM transactions in one cycle.

Test Plan:
- ADDR_W=4, CLEAR_ON_RESET=1, CLEAR_VAL=8'h5A, release reset → 16 consecutive ram_we cycles, addresses 0..15 with data 5A; clear_busy falls the cycle after the address-15 write.
- Same setup, vid_req at clear cycles 3 and 7 → clear stalls for those slots, vid_valid 3 cycles after each request, clear finishes after 18 slots.
- After clear: CPU write addr 0x0003 data 0xA5, then read 0x0003 → write ack 2 cycles after grant; read ack 3 cycles after grant with cpu_rdata=A5.
- vid_req and cpu_req (read) in same cycle → video slot first (vid_valid cycle 3), CPU granted cycle 1 (ack cycle 4).
- cpu_req held high across 3 reads → acks every 4 cycles, addresses follow updated cpu_addr, no duplicate grants.
- Assert reset_n=0 mid-clear and mid CPU read → all outputs return to reset values immediately, no cpu_ack, clear restarts at address 0.
